// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
//
// Purpose:
//   Shares one physical memory port between the instruction cache and the
//   data cache. The instruction cache only reads. The data cache reads and
//   writes. The arbiter runs one line transaction at a time. It returns
//   registered read data to the granted requester, together with a one-cycle
//   response pulse.
//
// Optional feature:
//   MEM_ARB_ROUND_ROBIN_EN
//     Defined:   when both sides are pending, the side that was not granted
//                last time wins.
//     Undefined: the data side always wins a conflict.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   i_read, i_address     instruction-side read request (level) and line address
//   i_rdata, i_resp       instruction-side read data and one-cycle completion
//   d_read, d_write       data-side request (level); read+write counts as write
//   d_address, d_wdata    data-side line address and write line
//   d_rdata, d_resp       data-side read data and one-cycle completion
//   pmem_read/pmem_write  memory strobes, held until pmem_resp
//   pmem_address/wdata    memory address and write line (registered)
//   pmem_rdata, pmem_resp memory read line and one-cycle completion
//   grant_d               1 while the data side owns the port
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              grant_d
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t              state_reg,    state_next;
   logic                grant_d_reg,  grant_d_next;
   logic                op_write_reg, op_write_next;
   logic [ADDR_W-1:0]   addr_reg,     addr_next;
   logic [LINE_W-1:0]   wdata_reg,    wdata_next;
   logic [LINE_W-1:0]   rdata_reg,    rdata_next;

   logic pending_i;
   logic pending_d;
   logic pick_d;
   logic busy;

   assign pending_i = i_read;
   assign pending_d = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // 1 = data side won the most recent grant. Reset makes the instruction
   // side the last winner, so the first conflict goes to the data side.
   logic last_grant_d_reg;

   // A conflict goes to whichever side did not win last time.
   assign pick_d = pending_d & (~pending_i | ~last_grant_d_reg);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_d_reg <= 1'b0;
      end else if (state_reg == IDLE && (pending_i || pending_d)) begin
         last_grant_d_reg <= pick_d;
      end
   end
`else
   // Fixed priority: the data side wins any conflict.
   assign pick_d = pending_d;
`endif

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         grant_d_reg  <= 1'b0;
         op_write_reg <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         grant_d_reg  <= grant_d_next;
         op_write_reg <= op_write_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         rdata_reg    <= rdata_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. Requester inputs are looked at only in IDLE. Once a
   // transaction is granted, it runs entirely from the registered copies.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      grant_d_next  = grant_d_reg;
      op_write_next = op_write_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      rdata_next    = rdata_reg;

      case (state_reg)
         IDLE: begin
            if (pending_i || pending_d) begin
               grant_d_next  = pick_d;
               // A read and a write asserted together are treated as a write.
               op_write_next = pick_d & d_write;
               addr_next     = pick_d ? d_address : i_address;
               wdata_next    = pick_d ? d_wdata : '0;
               state_next    = pick_d ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (pmem_resp) begin
               rdata_next = pmem_rdata;
               state_next = RESP;
            end
         end
         RESP: begin
            // The requester drops its request during this cycle, so IDLE
            // never sees the completed request again.
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs: decoded from the state or taken straight from registers.
   // ---------------------------------------------------------------------
   assign busy         = (state_reg == BUSY_I) || (state_reg == BUSY_D);
   assign pmem_read    = busy & ~op_write_reg;
   assign pmem_write   = busy &  op_write_reg;
   assign pmem_address = addr_reg;
   assign pmem_wdata   = wdata_reg;

   assign i_resp  = (state_reg == RESP) & ~grant_d_reg;
   assign d_resp  = (state_reg == RESP) &  grant_d_reg;
   assign i_rdata = i_resp ? rdata_reg : '0;
   assign d_rdata = d_resp ? rdata_reg : '0;
   assign grant_d = grant_d_reg & ((state_reg == BUSY_D) || (state_reg == RESP));

endmodule
